// File: rtl/fwft_frame_unpacker_pkg.sv
// Shared helpers for the FWFT frame unpacker: the segment-index width function and the FSM state type.
package fwft_frame_unpacker_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fwft_frame_unpacker.sv
// Pops FWFT words and streams them out LSB-segment first; pop-to-valid is 1 cycle and there are no bubbles at word edges.
// A stall (M_VALID & ~M_READY) freezes the beat and blocks pops. FWFT_UNPACK_STATS_EN adds the frame/word counters.
module fwft_frame_unpacker
  import fwft_frame_unpacker_pkg::*;
#(
  parameter int  IN_WIDTH  = 320,
  parameter int  OUT_WIDTH = 64,
  localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
  localparam int SEG_BITS  = clog2(RATIO + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IN_WIDTH-1:0]  FIFO_DATA,
  input  logic                 FIFO_LAST,
  input  logic [SEG_BITS-1:0]  FIFO_NSEG,
  input  logic                 FIFO_EMPTY,
  output logic                 FIFO_RD_EN,
  output logic [OUT_WIDTH-1:0] M_DATA,
  output logic                 M_VALID,
  input  logic                 M_READY,
  output logic                 M_LAST,
  output logic                 ERR_NSEG,
  output logic [31:0]          FRAME_CNT,
  output logic [31:0]          WORD_CNT
);

  localparam logic [SEG_BITS-1:0] RATIO_S = SEG_BITS'(RATIO);

  state_t              state;
  state_t              state_nxt;
  logic [IN_WIDTH-1:0] hold_word;
  logic [SEG_BITS-1:0] seg_idx;
  logic [SEG_BITS-1:0] seg_end;
  logic                last_word;
  logic                err_pulse;

  logic                valid;
  logic                acc;
  logic                eow;
  logic                pop;
  logic                nseg_ok;
  logic [SEG_BITS-1:0] nseg_eff;

  assign valid    = (state == SERVE);
  assign acc      = valid & M_READY;
  assign eow      = (seg_idx == (seg_end - SEG_BITS'(1)));
  // Refilling in the cycle the last segment is accepted keeps the stream gap-free.
  assign pop      = ~RST & ~FIFO_EMPTY & (~valid | (acc & eow));
  assign nseg_ok  = (FIFO_NSEG != '0) && (FIFO_NSEG <= RATIO_S);
  assign nseg_eff = nseg_ok ? FIFO_NSEG : RATIO_S;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pop) begin
      state_nxt = SERVE;
    end else if (acc && eow) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_word <= '0;
      seg_idx   <= '0;
      seg_end   <= RATIO_S;
      last_word <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= pop & FIFO_LAST & ~nseg_ok;
      if (pop) begin
        hold_word <= FIFO_DATA;
        seg_idx   <= '0;
        last_word <= FIFO_LAST;
        seg_end   <= FIFO_LAST ? nseg_eff : RATIO_S;
      end else if (acc && !eow) begin
        seg_idx <= seg_idx + SEG_BITS'(1);
      end
    end
  end

  always_comb begin
    M_DATA = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (seg_idx == SEG_BITS'(i)) begin
        M_DATA = hold_word[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  assign FIFO_RD_EN = pop;
  assign M_VALID    = valid;
  assign M_LAST     = valid & last_word & eow;
  assign ERR_NSEG   = err_pulse;

`ifdef FWFT_UNPACK_STATS_EN
  logic [31:0] frame_cnt;
  logic [31:0] word_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt <= '0;
      word_cnt  <= '0;
    end else begin
      if (pop) begin
        word_cnt <= word_cnt + 32'd1;
      end
      if (acc && M_LAST) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

  assign FRAME_CNT = frame_cnt;
  assign WORD_CNT  = word_cnt;
`else
  assign FRAME_CNT = '0;
  assign WORD_CNT  = '0;
`endif

endmodule
